// File: rtl/phy_read_burst_queue.sv
// Burst-granular capture queue between the DQ read path and the Read Buffer.
// Beats become visible to the reader only once their whole burst is captured.
module phy_read_burst_queue #(
  parameter int DATA_WIDTH   = 64,
  parameter int BURST_LENGTH = 8,
  parameter int NUM_BURSTS   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            read_ack,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_last,
  output logic [$clog2(NUM_BURSTS):0]     free_bursts,
  output logic                            overflow
);

  localparam int DEPTH = NUM_BURSTS * BURST_LENGTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = $clog2(BURST_LENGTH);
  localparam int OW    = AW + 1;
  localparam int CW    = $clog2(NUM_BURSTS) + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BW-1:0]         in_beat_q, in_beat_d, out_beat_q, out_beat_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic [CW-1:0]         committed_q, committed_d, free_q, free_d;
  logic                  read_ack_q, read_ack_d, overflow_q, overflow_d;
  logic                  full, wr_en, commit, pop, last_pop, mem_we;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    full      = (occ_q == OW'(DEPTH));
    out_valid = (committed_q != '0);
    pop       = out_valid && out_ready;
    last_pop  = pop && (out_beat_q == BW'(BURST_LENGTH - 1));
    wr_en     = in_valid && !full;
    commit    = wr_en && (in_beat_q == BW'(BURST_LENGTH - 1));
    mem_we    = wr_en && !flush;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    in_beat_d   = in_beat_q;
    out_beat_d  = out_beat_q;
    occ_d       = occ_q;
    committed_d = committed_q;
    read_ack_d  = 1'b0;
    overflow_d  = overflow_q;

    if (flush) begin
      // Any partial burst is dropped simply by rewinding both sides to slot 0.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      in_beat_d   = '0;
      out_beat_d  = '0;
      occ_d       = '0;
      committed_d = '0;
    end else begin
      overflow_d = overflow_q | (in_valid & full);
      read_ack_d = commit;
      if (wr_en) begin
        wr_ptr_d  = wr_ptr_q + 1'b1;
        in_beat_d = in_beat_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        out_beat_d = out_beat_q + 1'b1;
      end
      occ_d = occ_q + OW'(wr_en) - OW'(pop);
      case ({commit, last_pop})
        2'b10:   committed_d = committed_q + 1'b1;
        2'b01:   committed_d = committed_q - 1'b1;
        default: committed_d = committed_q;
      endcase
    end

    // Slots in use = ceil(occupancy / BURST_LENGTH); the sum cannot exceed 2*DEPTH-1.
    free_d = CW'(NUM_BURSTS) - CW'((occ_d + OW'(BURST_LENGTH - 1)) >> BW);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      in_beat_q   <= '0;
      out_beat_q  <= '0;
      occ_q       <= '0;
      committed_q <= '0;
      free_q      <= CW'(NUM_BURSTS);
      read_ack_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_beat_q   <= in_beat_d;
      out_beat_q  <= out_beat_d;
      occ_q       <= occ_d;
      committed_q <= committed_d;
      free_q      <= free_d;
      read_ack_q  <= read_ack_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: storage is deliberately not reset; out_valid gates every read of it,
  // and leaving it out of reset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_last    = out_valid && (out_beat_q == BW'(BURST_LENGTH - 1));
  assign read_ack    = read_ack_q;
  assign free_bursts = free_q;
  assign overflow    = overflow_q;

endmodule
